// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared FSM encoding and width constants for the APB master.
package apb_master_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} apb_state_e;
    localparam int APB_ADDR_W   = 8;
    localparam int APB_DATA_W   = 8;
    localparam int APB_TO_CNT_W = 8;
endpackage

// File: rtl/apb_master_timer.sv
// apb_master_timer: ACCESS-cycle watchdog; counts stalled cycles and flags when the limit is reached.
module apb_master_timer
    import apb_master_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    logic [APB_TO_CNT_W-1:0] cnt;
    assign expired = cnt == LIMIT[APB_TO_CNT_W-1:0];
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (tick) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single-outstanding APB master with valid/ready command and held response ports.
// Watchdog abort of stalled accesses is enabled with APB_MASTER_TIMEOUT_EN.
module apb_master_ctrl
    import apb_master_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [DATA_W-1:0] prdata
);
    apb_state_e state;
    logic       accept;
    logic       expired;
    assign accept = (state == ST_IDLE) && req_valid && req_ready;
`ifdef APB_MASTER_TIMEOUT_EN
    apb_master_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .pclk    (pclk),
        .preset  (preset),
        .clear   (accept),
        .tick    ((state == ST_ACCESS) && !pready),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state       <= ST_IDLE;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= !accept;
                    if (accept) begin
                        paddr  <= req_addr;
                        pwdata <= req_wdata;
                        pwrite <= req_write;
                        psel   <= 1'b1;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready wins over a watchdog expiry in the same cycle
                    if (pready || expired) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pready ? pslverr : 1'b1;
                        rsp_timeout <= !pready;
                        rsp_rdata   <= (pready && !pwrite) ? prdata : '0;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        req_ready   <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: scoreboard bench for apb_master_ctrl against a wait-state APB slave model.
module tb_apb_master_ctrl;
    logic       pclk, preset;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic       psel, penable, pwrite, pready, pslverr;
    logic [7:0] paddr, pwdata, prdata;

    apb_master_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    initial pclk = 0;
    always #5 pclk = ~pclk;

    // slave: registers below 0x20, pslverr above; prdata is junk unless pready
    logic [7:0] mem [256];
    int         waits, wcnt;
    logic       hang, stray;
    logic       acc_rdy;
    assign acc_rdy = psel && penable && !hang && (wcnt == waits);
    assign pready  = acc_rdy || stray;
    assign pslverr = pready && (paddr >= 8'h20);
    assign prdata  = !acc_rdy ? 8'h5A : (paddr >= 8'h20) ? 8'hEE : mem[paddr];
    always @(posedge pclk or posedge preset) begin
        if (preset) wcnt <= 0;
        else wcnt <= (psel && penable && !acc_rdy) ? wcnt + 1 : 0;
    end
    always @(posedge pclk) if (acc_rdy && pwrite && !pslverr) mem[paddr] <= pwdata;

    int         checks = 0, errors = 0;
    logic [9:0] sb [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic start(input logic w, input logic [7:0] a, input logic [7:0] d, input int ws,
                         input logic [7:0] erd, input logic eerr, input logic eto);
        int k = 0;
        waits = ws;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1;
        while (!req_ready && k < 20) begin @(negedge pclk); k++; end
        check("req_ready", 32'(req_ready), 1);
        sb.push_back({erd, eerr, eto});
        @(negedge pclk);
        req_valid = 0; req_addr = ~a; req_wdata = ~d; req_write = ~w;
        check("setup", 32'({psel, penable, req_ready}), 32'b100);
    endtask

    task automatic wait_rsp(input logic w, input logic [7:0] a, input int eedge);
        int k = 0;
        while (!rsp_valid && k < 40) begin
            @(negedge pclk); k++;
            if (k == 1) check("access_en", 32'({psel, penable}), 32'b11);
            if (psel) check("addr_hold", 32'({pwrite, paddr}), 32'({w, a}));
        end
        check("rsp_edge", 32'(k), 32'(eedge));
    endtask

    task automatic pop_check();
        logic [9:0] e;
        check("sb_depth", 32'(sb.size()), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rsp_rdata", 32'(rsp_rdata), 32'(e[9:2]));
            check("rsp_err", 32'(rsp_err), 32'(e[1]));
            check("rsp_timeout", 32'(rsp_timeout), 32'(e[0]));
            check("rsp_psel_low", 32'({psel, penable}), 0);
        end
    endtask

    task automatic ack();
        rsp_ready = 1;
        @(negedge pclk);
        rsp_ready = 0;
        check("ack", 32'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, req_ready}), 32'b1);
    endtask

    initial begin
        preset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        rsp_ready = 0; waits = 0; hang = 0; stray = 0;
        #1;
        check("reset_out", 32'({req_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite}), 0);
        check("reset_bus", 32'({paddr, pwdata, rsp_rdata}), 0);
        @(negedge pclk); @(negedge pclk);
        preset = 0;
        stray = 1;
        repeat (3) @(negedge pclk);
        stray = 0;
        check("stray_pready", 32'({rsp_valid, psel, req_ready}), 32'b001);

        start(1, 8'h05, 8'hA5, 2, 8'h00, 0, 0);
        wait_rsp(1, 8'h05, 4);
        pop_check();
        ack();
        check("mem05", 32'(mem[5]), 32'hA5);

        start(0, 8'h05, 8'h00, 2, 8'hA5, 0, 0);
        wait_rsp(0, 8'h05, 4);
        pop_check();
        ack();

        start(0, 8'h05, 8'h00, 0, 8'hA5, 0, 0);
        wait_rsp(0, 8'h05, 2);
        pop_check();
        ack();

        start(0, 8'h20, 8'h00, 0, 8'hEE, 1, 0);
        req_valid = 1; req_write = 0; req_addr = 8'h20;
        wait_rsp(0, 8'h20, 2);
        pop_check();
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            check("bp_hold", 32'({rsp_valid, rsp_err, rsp_timeout, req_ready, psel, rsp_rdata}),
                  32'({5'b11000, 8'hEE}));
        end
        rsp_ready = 1;
        @(negedge pclk);
        rsp_ready = 0;
        check("bp_release", 32'({rsp_valid, req_ready}), 32'b01);
        sb.push_back({8'hEE, 1'b1, 1'b0});
        @(negedge pclk);
        req_valid = 0;
        check("bp_accept", 32'({psel, penable, req_ready}), 32'b100);
        wait_rsp(0, 8'h20, 2);
        pop_check();
        ack();

`ifdef APB_MASTER_TIMEOUT_EN
        hang = 1;
        start(0, 8'h05, 8'h00, 0, 8'h00, 1, 1);
        wait_rsp(0, 8'h05, 18);
        pop_check();
        ack();
        hang = 0;
`else
        hang = 1;
        start(0, 8'h05, 8'h00, 0, 8'h00, 0, 0);
        repeat (40) @(negedge pclk);
        check("no_timeout", 32'({rsp_valid, psel, penable, rsp_timeout}), 32'b0110);
        preset = 1;
        @(negedge pclk);
        preset = 0;
        sb.delete();
        hang = 0;
`endif

        start(1, 8'h07, 8'h3C, 5, 8'h00, 0, 0);
        @(negedge pclk); @(negedge pclk);
        check("mid_access", 32'({psel, penable}), 32'b11);
        #1 preset = 1;
        #1 check("reset_async", 32'({psel, penable, rsp_valid, req_ready, pwrite, paddr, pwdata}), 0);
        sb.delete();
        repeat (3) begin
            @(negedge pclk);
            check("reset_no_rsp", 32'({rsp_valid, psel}), 0);
        end
        preset = 0;
        @(negedge pclk);
        check("post_reset_ready", 32'({req_ready, rsp_valid}), 32'b10);
        start(1, 8'h07, 8'h3C, 1, 8'h00, 0, 0);
        wait_rsp(1, 8'h07, 3);
        pop_check();
        ack();
        start(0, 8'h07, 8'h00, 1, 8'h3C, 0, 0);
        wait_rsp(0, 8'h07, 3);
        pop_check();
        ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
